// File: rtl/alu_bist_pkg.sv
// Shared types and constants for the ALU built-in self-test controller:
// FSM states, LFSR feedback polynomial, flag bit positions and the LFSR step.
package alu_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } bist_state_t;

    // Galois taps for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    localparam int FLAG_ZF = 0;
    localparam int FLAG_BF = 1;
    localparam int FLAG_PF = 2;
    localparam int FLAG_VF = 3;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'd0);
    endfunction

endpackage

// File: rtl/alu_bist_lfsr.sv
// 32-bit Galois LFSR operand source: loads the seed, steps on request and
// exposes the low OUT_W state bits used as operands.
module alu_bist_lfsr
    import alu_bist_pkg::*;
#(
    parameter logic [31:0] SEED  = 32'd1,
    parameter int          OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    output logic [OUT_W-1:0] state
);

    // An all-zero state would lock the LFSR, so a zero seed becomes 1
    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

    logic [31:0] lfsr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_reg <= SEED_EFF;
        end else if (load) begin
            lfsr_reg <= SEED_EFF;
        end else if (step) begin
            lfsr_reg <= lfsr_step(lfsr_reg);
        end
    end

    assign state = lfsr_reg[OUT_W-1:0];

endmodule

// File: rtl/alu_bist_ctrl.sv
// BIST controller driving two ALU implementations with LFSR vectors and tallying
// result/flag agreement. Optional first-fail capture: define BIST_FIRST_FAIL_EN.
module alu_bist_ctrl
    import alu_bist_pkg::*;
#(
    parameter int          M           = 8,
    parameter int          N           = 4,
    parameter int          NUM_VECTORS = 500,
    parameter int          LAT         = 0,
    parameter int          CNT_W       = 16,
    parameter logic [31:0] SEED        = 32'd1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    output logic [M-1:0]     o_argA,
    output logic [M-1:0]     o_argB,
    output logic [N-1:0]     o_oper,
    input  logic [M-1:0]     i_result_model,
    input  logic [M-1:0]     i_result_synth,
    input  logic [3:0]       i_flags_model,
    input  logic [3:0]       i_flags_synth,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [CNT_W-1:0] o_err_result_cnt,
    output logic [CNT_W-1:0] o_err_flag_cnt,
    output logic [CNT_W-1:0] o_ok_result_cnt,
    output logic [CNT_W-1:0] o_ok_flag_cnt
`ifdef BIST_FIRST_FAIL_EN
    ,
    output logic             o_ff_valid,
    output logic [CNT_W-1:0] o_ff_index,
    output logic [N-1:0]     o_ff_oper,
    output logic [M-1:0]     o_ff_argA,
    output logic [M-1:0]     o_ff_argB
`endif
);

    localparam int IDX_W  = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
    localparam int HOLD_W = (LAT > 0) ? $clog2(LAT + 1) : 1;

    bist_state_t       state_reg, state_next;
    logic [HOLD_W-1:0] hold_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [N-1:0]      oper_reg;
    logic [CNT_W-1:0]  err_result_reg, err_flag_reg, ok_result_reg, ok_flag_reg;
    logic [2*M-1:0]    lfsr_ops;

    logic start_go, cmp_go, last_go;
    logic result_miss, flag_miss;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    alu_bist_lfsr #(
        .SEED  (SEED),
        .OUT_W (2 * M)
    ) u_lfsr (
        .clk   (i_clk),
        .rst   (i_rst),
        .load  (start_go),
        .step  (cmp_go),
        .state (lfsr_ops)
    );

    // Case-inequality so that X/Z from either ALU is reported as a mismatch
    assign result_miss = (i_result_model !== i_result_synth);
    assign flag_miss   = (i_flags_model[FLAG_ZF] !== i_flags_synth[FLAG_ZF]) ||
                         (i_flags_model[FLAG_BF] !== i_flags_synth[FLAG_BF]) ||
                         (i_flags_model[FLAG_PF] !== i_flags_synth[FLAG_PF]) ||
                         (i_flags_model[FLAG_VF] !== i_flags_synth[FLAG_VF]);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        start_go   = 1'b0;
        cmp_go     = 1'b0;
        last_go    = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    start_go   = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (hold_reg == HOLD_W'(LAT)) begin
                    cmp_go  = 1'b1;
                    last_go = (idx_reg == IDX_W'(NUM_VECTORS - 1));
                end
                if (last_go) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hold_reg       <= '0;
            idx_reg        <= '0;
            oper_reg       <= '0;
            err_result_reg <= '0;
            err_flag_reg   <= '0;
            ok_result_reg  <= '0;
            ok_flag_reg    <= '0;
        end else if (start_go) begin
            hold_reg       <= '0;
            idx_reg        <= '0;
            oper_reg       <= '0;
            err_result_reg <= '0;
            err_flag_reg   <= '0;
            ok_result_reg  <= '0;
            ok_flag_reg    <= '0;
        end else if (cmp_go) begin
            hold_reg <= '0;
            idx_reg  <= idx_reg + IDX_W'(1);
            oper_reg <= oper_reg + N'(1);
            if (result_miss) err_result_reg <= sat_inc(err_result_reg);
            else             ok_result_reg  <= sat_inc(ok_result_reg);
            if (flag_miss)   err_flag_reg   <= sat_inc(err_flag_reg);
            else             ok_flag_reg    <= sat_inc(ok_flag_reg);
        end else if (state_reg == ST_RUN) begin
            hold_reg <= hold_reg + HOLD_W'(1);
        end
    end

    // IDLE is only reachable through reset, where the operands must read zero
    // even though the LFSR already holds the seed.
    assign o_argA = (state_reg == ST_IDLE) ? '0 : lfsr_ops[M-1:0];
    assign o_argB = (state_reg == ST_IDLE) ? '0 : lfsr_ops[2*M-1:M];
    assign o_oper = oper_reg;

    assign o_busy = (state_reg == ST_RUN);
    assign o_done = (state_reg == ST_DONE);
    assign o_pass = (state_reg == ST_DONE) && (err_result_reg == '0) && (err_flag_reg == '0);

    assign o_err_result_cnt = err_result_reg;
    assign o_err_flag_cnt   = err_flag_reg;
    assign o_ok_result_cnt  = ok_result_reg;
    assign o_ok_flag_cnt    = ok_flag_reg;

`ifdef BIST_FIRST_FAIL_EN
    logic             ff_valid_reg;
    logic [CNT_W-1:0] ff_index_reg;
    logic [N-1:0]     ff_oper_reg;
    logic [M-1:0]     ff_arg_a_reg, ff_arg_b_reg;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ff_valid_reg <= 1'b0;
            ff_index_reg <= '0;
            ff_oper_reg  <= '0;
            ff_arg_a_reg <= '0;
            ff_arg_b_reg <= '0;
        end else if (start_go) begin
            ff_valid_reg <= 1'b0;
            ff_index_reg <= '0;
            ff_oper_reg  <= '0;
            ff_arg_a_reg <= '0;
            ff_arg_b_reg <= '0;
        end else if (cmp_go && (result_miss || flag_miss) && !ff_valid_reg) begin
            ff_valid_reg <= 1'b1;
            ff_index_reg <= CNT_W'(idx_reg);
            ff_oper_reg  <= oper_reg;
            ff_arg_a_reg <= o_argA;
            ff_arg_b_reg <= o_argB;
        end
    end

    assign o_ff_valid = ff_valid_reg;
    assign o_ff_index = ff_index_reg;
    assign o_ff_oper  = ff_oper_reg;
    assign o_ff_argA  = ff_arg_a_reg;
    assign o_ff_argB  = ff_arg_b_reg;
`endif

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Self-checking bench for alu_bist_ctrl: a default instance and a LAT=2 / CNT_W=8 /
// 300-vector instance, checked against a behavioural model of the vector stream.
module tb_alu_bist_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start1 = 1'b0, start2 = 1'b0;
    logic [7:0] rm1 = '0, rs1 = '0, rm2 = '0, rs2 = '0;
    logic [3:0] fm1 = '0, fs1 = '0, fm2 = '0, fs2 = '0;

    logic [7:0]  a1, b1, a2, b2;
    logic [3:0]  op1, op2;
    logic        busy1, done1, pass1, busy2, done2, pass2;
    logic [15:0] er1, ef1, or1, of1;
    logic [7:0]  er2, ef2, or2, of2;
`ifdef BIST_FIRST_FAIL_EN
    logic        ffv1, ffv2;
    logic [15:0] ffi1;
    logic [7:0]  ffi2;
    logic [3:0]  ffo1, ffo2;
    logic [7:0]  ffa1, ffb1, ffa2, ffb2;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] obs_a, obs_b, obs_op, obs_busy, obs_done, obs_pass;
    logic [31:0] obs_er, obs_ef, obs_or, obs_of;

    always #5 clk = ~clk;

    alu_bist_ctrl dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1),
        .o_argA(a1), .o_argB(b1), .o_oper(op1),
        .i_result_model(rm1), .i_result_synth(rs1),
        .i_flags_model(fm1), .i_flags_synth(fs1),
        .o_busy(busy1), .o_done(done1), .o_pass(pass1),
        .o_err_result_cnt(er1), .o_err_flag_cnt(ef1),
        .o_ok_result_cnt(or1), .o_ok_flag_cnt(of1)
`ifdef BIST_FIRST_FAIL_EN
        , .o_ff_valid(ffv1), .o_ff_index(ffi1), .o_ff_oper(ffo1),
        .o_ff_argA(ffa1), .o_ff_argB(ffb1)
`endif
    );

    alu_bist_ctrl #(.NUM_VECTORS(300), .LAT(2), .CNT_W(8)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(start2),
        .o_argA(a2), .o_argB(b2), .o_oper(op2),
        .i_result_model(rm2), .i_result_synth(rs2),
        .i_flags_model(fm2), .i_flags_synth(fs2),
        .o_busy(busy2), .o_done(done2), .o_pass(pass2),
        .o_err_result_cnt(er2), .o_err_flag_cnt(ef2),
        .o_ok_result_cnt(or2), .o_ok_flag_cnt(of2)
`ifdef BIST_FIRST_FAIL_EN
        , .o_ff_valid(ffv2), .o_ff_index(ffi2), .o_ff_oper(ffo2),
        .o_ff_argA(ffa2), .o_ff_argB(ffb2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int sel);
        if (sel == 0) begin
            obs_a = a1; obs_b = b1; obs_op = op1;
            obs_busy = busy1; obs_done = done1; obs_pass = pass1;
            obs_er = er1; obs_ef = ef1; obs_or = or1; obs_of = of1;
        end else begin
            obs_a = a2; obs_b = b2; obs_op = op2;
            obs_busy = busy2; obs_done = done2; obs_pass = pass2;
            obs_er = er2; obs_ef = ef2; obs_or = or2; obs_of = of2;
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start1 = v;
        else          start2 = v;
    endtask

    task automatic drive(input int sel, input logic [7:0] rm, input logic [7:0] rs,
                         input logic [3:0] fm, input logic [3:0] fs);
        if (sel == 0) begin rm1 = rm; rs1 = rs; fm1 = fm; fs1 = fs; end
        else          begin rm2 = rm; rs2 = rs; fm2 = fm; fs2 = fs; end
    endtask

    task automatic chk_all_zero(input int sel, input string tag);
        sample(sel);
        chk({tag, "_argA"}, obs_a, 0);
        chk({tag, "_argB"}, obs_b, 0);
        chk({tag, "_oper"}, obs_op, 0);
        chk({tag, "_busy"}, obs_busy, 0);
        chk({tag, "_done"}, obs_done, 0);
        chk({tag, "_pass"}, obs_pass, 0);
        chk({tag, "_err_res"}, obs_er, 0);
        chk({tag, "_err_flg"}, obs_ef, 0);
        chk({tag, "_ok_res"}, obs_or, 0);
        chk({tag, "_ok_flg"}, obs_of, 0);
    endtask

    // mode 0: ALUs agree; mode 1: result off by bit 0 at err_idx; mode 2: flags always differ.
    // abort_at >= 0 asserts reset when that vector is first presented.
    task automatic run(input int sel, input int nv, input int lat, input int cmax,
                       input int mode, input int err_idx, input int abort_at);
        logic [31:0] lf;
        logic [7:0]  r, rs;
        logic [3:0]  f, fs;
        int er, ef, okr, okf, ffi;
        logic [7:0] ffa, ffb;
        logic [3:0] ffo;
        lf = 32'd1;
        er = 0; ef = 0; okr = 0; okf = 0; ffi = -1;
        ffa = '0; ffb = '0; ffo = '0;
        set_start(sel, 1'b1);
        @(negedge clk);
        for (int v = 0; v < nv; v++) begin
            for (int h = 0; h <= lat; h++) begin
                if (v == abort_at && h == 0) begin
                    rst = 1'b1;
                    set_start(sel, 1'b0);
                    #1;
                    chk_all_zero(sel, "abort");
                    @(negedge clk);
                    rst = 1'b0;
                    $display("run sel=%0d aborted by reset at vector %0d", sel, v);
                    return;
                end
                sample(sel);
                chk("busy", obs_busy, 1);
                chk("done_in_run", obs_done, 0);
                chk("argA", obs_a, {24'd0, lf[7:0]});
                chk("argB", obs_b, {24'd0, lf[15:8]});
                chk("oper", obs_op, v % 16);
                // start during RUN must have no effect
                set_start(sel, 1'($urandom_range(0, 1)));
                r  = 8'($urandom);
                f  = 4'($urandom);
                rs = (mode == 1 && v == err_idx) ? (r ^ 8'h01) : r;
                fs = (mode == 2) ? ~f : f;
                drive(sel, r, rs, f, fs);
                if (h == lat) begin
                    if (rs != r) er  = (er  < cmax) ? er  + 1 : er;
                    else         okr = (okr < cmax) ? okr + 1 : okr;
                    if (fs != f) ef  = (ef  < cmax) ? ef  + 1 : ef;
                    else         okf = (okf < cmax) ? okf + 1 : okf;
                    if ((rs != r || fs != f) && ffi < 0) begin
                        ffi = v; ffa = lf[7:0]; ffb = lf[15:8]; ffo = 4'(v % 16);
                    end
                    lf = (lf >> 1) ^ ((lf & 32'd1) != 0 ? 32'h8020_0003 : 32'd0);
                end
                @(negedge clk);
            end
        end
        set_start(sel, 1'b0);
        for (int k = 0; k < 3; k++) begin
            sample(sel);
            chk("done", obs_done, 1);
            chk("busy_after", obs_busy, 0);
            chk("pass", obs_pass, (er == 0 && ef == 0) ? 1 : 0);
            chk("err_result", obs_er, er);
            chk("err_flag", obs_ef, ef);
            chk("ok_result", obs_or, okr);
            chk("ok_flag", obs_of, okf);
            @(negedge clk);
        end
`ifdef BIST_FIRST_FAIL_EN
        if (sel == 0) begin
            chk("ff_valid", {31'd0, ffv1}, (ffi >= 0) ? 1 : 0);
            if (ffi >= 0) begin
                chk("ff_index", {16'd0, ffi1}, ffi);
                chk("ff_oper", {28'd0, ffo1}, {28'd0, ffo});
                chk("ff_argA", {24'd0, ffa1}, {24'd0, ffa});
                chk("ff_argB", {24'd0, ffb1}, {24'd0, ffb});
            end
        end
`endif
        $display("run sel=%0d nv=%0d lat=%0d mode=%0d: err_res=%0d err_flg=%0d ok_res=%0d ok_flg=%0d",
                 sel, nv, lat, mode, er, ef, okr, okf);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero(0, "rst1");
        chk_all_zero(1, "rst2");
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero(0, "idle1");
        $display("reset checked");

        run(0, 500, 0, 65535, 0, -1, -1);
        run(0, 500, 0, 65535, 1, 10, -1);
        run(0, 500, 0, 65535, 1, int'($urandom_range(0, 499)), -1);
        run(0, 500, 0, 65535, 0, -1, 100);
        run(0, 500, 0, 65535, 0, -1, -1);
        run(1, 300, 2, 255, 2, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_bist_ctrl.md
ALU_BIST_CTRL -- requirements
Module: alu_bist_ctrl

Interface
REQ-001 SHALL have parameter M, default 8, operand/result width (2..16).
REQ-002 SHALL have parameter N, default 4, opcode width.
REQ-003 SHALL have parameter NUM_VECTORS, default 500, vectors per run (>=1).
REQ-004 SHALL have parameter LAT, default 0, DUT latency in cycles; each vector is held LAT+1 cycles.
REQ-005 SHALL have parameter CNT_W, default 16, counter width.
REQ-006 SHALL have parameter SEED, default 32'd1, LFSR seed; a value of 0 is replaced by 1.
REQ-007 SHALL have: i_clk  in  1  clock, all state on rising edge.
REQ-008 SHALL have: i_rst  in  1  asynchronous, active-high reset.
REQ-009 SHALL have: i_start  in  1  start pulse.
REQ-010 SHALL have: o_argA, o_argB  out  M  operands to both DUTs; o_oper  out  N  opcode.
REQ-011 SHALL have: i_result_model, i_result_synth  in  M  DUT results.
REQ-012 SHALL have: i_flags_model, i_flags_synth  in  4  flags, ordered [0]ZF [1]BF [2]PF [3]VF.
REQ-013 SHALL have: o_busy, o_done, o_pass  out  1  status.
REQ-014 SHALL have: o_err_result_cnt, o_err_flag_cnt, o_ok_result_cnt, o_ok_flag_cnt  out  CNT_W  tallies.

Function
REQ-015 SHALL implement an FSM IDLE -> RUN -> DONE; o_busy=1 only in RUN, o_done=1 only in DONE.
REQ-016 IDLE or DONE with i_start=1 SHALL enter RUN next cycle, load LFSR=SEED, oper=0, vector index=0, hold=0, clear all counters and o_pass.
REQ-017 i_start in RUN SHALL be ignored.
REQ-018 Operands SHALL come from a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1: o_argA=lfsr[M-1:0], o_argB=lfsr[2M-1:M].
REQ-019 In RUN the hold counter SHALL count 0..LAT; on the edge where hold==LAT the inputs SHALL be compared with !== semantics (X/Z counts as mismatch).
REQ-020 On that compare edge: result mismatch -> err_result+1 else ok_result+1; flags compared likewise and independently; then LFSR advances one step, oper increments modulo 2^N, index increments, hold returns to 0.
REQ-021 All counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-022 The compare of index NUM_VECTORS-1 SHALL move the FSM to DONE on the same edge.
REQ-023 In DONE o_pass SHALL be 1 iff both error counters are zero; counters and operands SHALL hold until the next start.
REQ-024 A run SHALL take exactly NUM_VECTORS*(LAT+1) cycles in RUN.

Reset
REQ-025 i_rst SHALL immediately force IDLE, operands/oper 0, LFSR SEED, all counters 0, o_busy/o_done/o_pass 0, including mid-RUN.

Configuration
REQ-026 With BIST_FIRST_FAIL_EN defined: extra outputs o_ff_valid (1), o_ff_index (CNT_W), o_ff_oper (N), o_ff_argA/o_ff_argB (M) SHALL capture the first vector failing result or flags; cleared at start/reset.
REQ-027 Without BIST_FIRST_FAIL_EN those ports and registers SHALL not exist.

Structure
REQ-028 Package alu_bist_pkg SHALL hold the FSM state typedef, LFSR polynomial constant and flag bit index constants.
REQ-029 Sub-module alu_bist_lfsr SHALL implement the LFSR (load, step, state out).

Verification
REQ-030 Model and synth inputs tied together, defaults -> o_done 500 cycles after start, o_pass=1, ok counts 500, errors 0.
REQ-031 Synth result = model^1 at index 10 only -> err_result=1, err_flag=0, o_pass=0; with macro o_ff_index=10.
REQ-032 Flags stuck mismatched, CNT_W=8, NUM_VECTORS=300 -> o_err_flag_cnt=255, ok_flag=0.
REQ-033 LAT=2 -> each operand held 3 cycles, o_done after 1500 cycles.
REQ-034 Reset asserted at index 100 -> all outputs 0 next edge; new start yields full 500-vector run identical to REQ-030.
REQ-035 N=4 -> o_oper sequence 0..15 then 0 at index 16; start while RUN changes nothing.
